// File: rtl/seq_divider_16by8.sv
// Sequential 16-by-8 unsigned restoring divider: one quotient bit per clock, fixed latency.
// Define DIV_ZERO_DETECT_EN to short-cut zero divisors and flag them on div_by_zero.
module seq_divider_16by8 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic        busy,
   output logic        done,
   output logic [15:0] quotient,
   output logic [7:0]  remainder,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FINISH
   } state_e;

   localparam logic [4:0] LAST_CNT = 5'd16;

   state_e      state_q, state_d;
   // The dividend register doubles as the quotient: each iteration shifts one
   // dividend bit out of the top and one quotient bit in at the bottom.
   logic [15:0] dvd_q, dvd_d;
   logic [7:0]  dsr_q, dsr_d;
   logic [8:0]  prem_q, prem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] quot_q, quot_d;
   logic [7:0]  rem_q, rem_d;

   logic [8:0]  shifted;
   logic [9:0]  trial;
   logic        qbit;
   logic        zero_skip;

`ifdef DIV_ZERO_DETECT_EN
   logic        dbz_q, dbz_d;
   assign zero_skip   = (dsr_q == 8'd0);
   assign div_by_zero = dbz_q;
`else
   assign zero_skip   = 1'b0;
   assign div_by_zero = 1'b0;
`endif

   // Restoring step: a borrow out of the 10-bit trial means "keep the shifted value".
   assign shifted = {prem_q[7:0], dvd_q[15]};
   assign trial   = {1'b0, shifted} - {2'b00, dsr_q};
   assign qbit    = ~trial[9];

   // NOTE: every always_comb output gets a default first, so no path leaves a latch.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
      dbz_d   = dbz_q;
`endif
      busy    = 1'b0;
      done    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               dvd_d   = dividend;
               dsr_d   = divisor;
               prem_d  = 9'd0;
               cnt_d   = 5'd0;
               state_d = ST_CALC;
            end
         end

         ST_CALC: begin
            busy = 1'b1;
            if (zero_skip) begin
               quot_d  = 16'hFFFF;
               rem_d   = dvd_q[7:0];
`ifdef DIV_ZERO_DETECT_EN
               dbz_d   = 1'b1;
`endif
               state_d = ST_FINISH;
            end else if (cnt_q == LAST_CNT) begin
               quot_d  = dvd_q;
               rem_d   = prem_q[7:0];
`ifdef DIV_ZERO_DETECT_EN
               dbz_d   = 1'b0;
`endif
               state_d = ST_FINISH;
            end else begin
               prem_d = qbit ? trial[8:0] : shifted;
               dvd_d  = {dvd_q[14:0], qbit};
               cnt_d  = cnt_q + 5'd1;
            end
         end

         ST_FINISH: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dvd_q   <= 16'd0;
         dsr_q   <= 8'd0;
         prem_q  <= 9'd0;
         cnt_q   <= 5'd0;
         quot_q  <= 16'd0;
         rem_q   <= 8'd0;
`ifdef DIV_ZERO_DETECT_EN
         dbz_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
         dbz_q   <= dbz_d;
`endif
      end
   end

   assign quotient  = quot_q;
   assign remainder = rem_q;

   a_done_single : assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
   a_busy_done   : assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));

endmodule

// File: doc/seq_divider_16by8.md
SEQ_DIVIDER_16BY8 -- requirements
Module: seq_divider_16by8

Interface
REQ-001 The block SHALL have no parameters; widths are fixed (16-bit dividend, 8-bit divisor).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; SHALL be sampled only while busy=0.
REQ-005 dividend  input  16  unsigned dividend; SHALL be captured on the accepting edge.
REQ-006 divisor  input  8  unsigned divisor; SHALL be captured on the accepting edge.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; results are valid on this cycle.
REQ-009 quotient  output  16  unsigned quotient; registered.
REQ-010 remainder  output  8  unsigned remainder; registered.
REQ-011 div_by_zero  output  1  high with done when the captured divisor was 0.

Function
REQ-012 The block SHALL implement an FSM with three states:
- IDLE: waiting for start.
- CALC: iterating.
- FINISH: one cycle, drives done.
REQ-013 IDLE->CALC SHALL occur on an edge with start=1. On that edge the block SHALL:
- capture the operands;
- clear the 9-bit partial remainder;
- clear the 5-bit iteration counter;
- set busy=1.
REQ-014 CALC SHALL run restoring division, one quotient bit per edge, MSB first. Each edge:
- shift the partial remainder left and bring in the next dividend bit;
- subtract the divisor if the result is >= 0 and set the quotient bit to 1, else set it to 0.
REQ-015 After exactly 16 CALC edges the FSM SHALL enter FINISH. That edge SHALL register quotient and remainder[7:0].
REQ-016 In FINISH: done=1 and busy=0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be fixed: accepting edge k -> done high in the cycle following edge k+17. This holds for all nonzero divisors, including divisor > dividend.
REQ-018 start SHALL be ignored while busy=1 or in FINISH; the captured operands SHALL NOT change.
REQ-019 quotient, remainder and div_by_zero SHALL hold their last values until the next FINISH.
REQ-020 A back-to-back start (start=1 on the cycle done=1) SHALL be ignored. The earliest next acceptance is the cycle after done.
REQ-021 Results SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor, for every divisor != 0.
REQ-022 For divisor=0, outputs SHALL be quotient=16'hFFFF and remainder=dividend[7:0]. This is the natural restoring result, and the value is identical in both configurations.

Reset
REQ-023 rst_n=0 SHALL immediately force:
- state=IDLE, busy=0, done=0;
- quotient=0, remainder=0, div_by_zero=0;
- counter=0, partial remainder=0.
REQ-024 Reset asserted mid-CALC SHALL abort the operation with no done pulse. The first start after release SHALL follow REQ-017 exactly.
REQ-025 Deassertion of rst_n is synchronous-release by convention. The block SHALL accept start on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro DIV_ZERO_DETECT_EN:
- Defined: a zero divisor SHALL skip CALC. The FSM goes IDLE->FINISH on the edge after acceptance (done in the cycle after edge k+1), with the REQ-022 values and div_by_zero=1.
- Undefined: a zero divisor SHALL take the full 17-edge latency with the REQ-022 values, and div_by_zero SHALL be tied to 0.
REQ-027 In both configurations div_by_zero SHALL be 0 for every nonzero divisor.

Verification
REQ-028 dividend=5, divisor=3 -> quotient=1, remainder=2, done 17 edges after acceptance, busy high 17 cycles.
REQ-029 dividend=91, divisor=44 -> quotient=2, remainder=3. Then dividend=16'hCDBA, divisor=8'hFE -> quotient=16'h00CF, remainder=8'h58.
REQ-030 dividend=16'hFFFF, divisor=8'h01 -> quotient=16'hFFFF, remainder=0. Then dividend=16'h0003, divisor=8'hFF -> quotient=0, remainder=3.
REQ-031 dividend=16'h1234, divisor=0:
- With DIV_ZERO_DETECT_EN: quotient=16'hFFFF, remainder=8'h34, div_by_zero=1, done 1 edge after acceptance.
- Without: same values, div_by_zero=0, done after 17 edges.
REQ-032 start pulsed with new operands while busy -> ignored; the original result is produced unchanged.
REQ-033 rst_n pulsed low at iteration 8 -> all outputs 0 immediately, no done pulse. A new start of 100/7 -> quotient=14, remainder=2, with nominal latency.
